// File: rtl/dh_pkg.sv
// Shared definitions for the status-word UART transmitter.
package dh_pkg;

  // Status words produced by the key-exchange controller
  localparam logic [47:0] STAT_ACCEPT = 48'h414343455054;  // "ACCEPT"
  localparam logic [47:0] STAT_IDLE   = 48'h0;

  // Characters per status word
  localparam int MSG_BYTES = 6;

  // Per-byte serialiser state
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_byte_tx.sv
// Sends one 8N1 frame. data_i is read live at each data-bit boundary, so the
// caller must hold it stable for the whole frame. A new start accepted during
// the final stop-bit cycle chains the next frame with no gap.
module uart_byte_tx
  import dh_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       last_o,
  output logic       tx_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic             tx_q, tx_d;

  logic       bit_tick;
  logic [2:0] bit_nx;

  assign bit_tick = (cnt_q == CNT_MAX);
  assign bit_nx   = bit_q + 3'd1;
  assign last_o   = (state_q == TX_STOP) && bit_tick;
  assign ready_o  = (state_q == TX_IDLE) || last_o;
  assign tx_o     = tx_q;

  // State, counters and the registered line output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic; tx_d is the level the line takes from the next edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    case (state_q)
      TX_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (start_i) begin
          state_d = TX_START;
          tx_d    = 1'b0;
        end
      end
      TX_START: begin
        if (bit_tick) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = TX_DATA;
          tx_d    = data_i[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nx;
            tx_d  = data_i[bit_nx];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (start_i) begin
            state_d = TX_START;
            tx_d    = 1'b0;
          end else begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dh_status_uart_tx.sv
// Captures a 48-bit status word and streams its six characters, MSB byte
// first, over an 8N1 UART line. Flags requests that arrive while busy.
module dh_status_uart_tx
  import dh_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] msg_in,
  input  logic        msg_valid,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  logic [47:0] shreg_q, shreg_d;
  logic [2:0]  bytes_q, bytes_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        overrun_q, overrun_d;

  logic capture;
  logic byte_last;
  logic byte_ready;
  logic byte_start;

  assign capture    = msg_valid && !busy_q;
  assign byte_start = (capture || (byte_last && (bytes_q != 3'd0))) && byte_ready;

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk    (clk),
    .rst    (rst),
    .start_i(byte_start),
    .data_i (shreg_q[47:40]),
    .ready_o(byte_ready),
    .last_o (byte_last),
    .tx_o   (tx)
  );

  // Message-level registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q   <= '0;
      bytes_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bytes_q   <= bytes_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  // Capture, per-byte shifting, completion and the sticky overrun flag
  always_comb begin
    shreg_d   = shreg_q;
    bytes_d   = bytes_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = overrun_q || (msg_valid && busy_q);
    if (capture) begin
      shreg_d = msg_in;
      bytes_d = 3'(MSG_BYTES - 1);
      busy_d  = 1'b1;
    end else if (byte_last) begin
      if (bytes_q != 3'd0) begin
        shreg_d = {shreg_q[39:0], 8'h00};
        bytes_d = bytes_q - 3'd1;
      end else begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_dh_status_uart_tx.sv
// Directed bench for dh_status_uart_tx at CLKS_PER_BIT=4.
module tb_dh_status_uart_tx;

  localparam int          CPB    = 4;
  localparam logic [47:0] ACCEPT = 48'h414343455054;
  localparam logic [47:0] B2B    = 48'h0102030405FF;

  logic        clk;
  logic        rst;
  logic [47:0] msg_in;
  logic        msg_valid;
  logic        tx;
  logic        busy;
  logic        done;
  logic        overrun;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int cap      = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  dh_status_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .msg_in   (msg_in),
    .msg_valid(msg_valid),
    .tx       (tx),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the first negedge of a start bit; returns at the next frame's first negedge
  task automatic recv_byte(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    logic [3:0] s;
    b = 8'h00;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < CPB; j++) begin
        s[j] = tx;
        @(negedge clk);
      end
      check($sformatf("%s bit%0d stable", tag, k), {63'd0, (s == 4'b0000) || (s == 4'b1111)}, 64'd1);
      if (k == 0)      check($sformatf("%s start", tag), {63'd0, s[0]}, 64'd0);
      else if (k == 9) check($sformatf("%s stop", tag), {63'd0, s[0]}, 64'd1);
      else             b[k-1] = s[0];
    end
    check($sformatf("%s data", tag), {56'd0, b}, {56'd0, exp});
    $display("rx %s byte=%02h expected=%02h", tag, b, exp);
  endtask

  task automatic send_msg(input string tag, input logic [47:0] m);
    msg_in    = m;
    msg_valid = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
    cap      = cyc;
    done_cnt = 0;
    check({tag, " cap tx"}, {63'd0, tx}, 64'd0);
    check({tag, " cap busy"}, {63'd0, busy}, 64'd1);
  endtask

  task automatic recv_msg(input string tag, input logic [47:0] m);
    for (int i = 0; i < 6; i++) begin
      recv_byte($sformatf("%s b%0d", tag, i), m[47-8*i -: 8]);
    end
    check({tag, " end tx"}, {63'd0, tx}, 64'd1);
    check({tag, " end busy"}, {63'd0, busy}, 64'd0);
    check({tag, " end done"}, {63'd0, done}, 64'd1);
  endtask

  task automatic check_done(input string tag);
    check({tag, " done count"}, 64'(done_cnt), 64'd1);
    check({tag, " done latency"}, 64'(done_cyc - cap), 64'(60 * CPB));
  endtask

  initial begin
    rst       = 1'b1;
    msg_in    = '0;
    msg_valid = 1'b0;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst tx", {63'd0, tx}, 64'd1);
      check("rst busy", {63'd0, busy}, 64'd0);
      check("rst done", {63'd0, done}, 64'd0);
      check("rst overrun", {63'd0, overrun}, 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Single ACCEPT message
    send_msg("accept", ACCEPT);
    recv_msg("accept", ACCEPT);
    @(negedge clk);
    check_done("accept");
    check("accept overrun", {63'd0, overrun}, 64'd0);
    repeat (3) @(negedge clk);

    // Request dropped at cycle 50 of a message
    send_msg("ovr", ACCEPT);
    fork
      recv_msg("ovr", ACCEPT);
      begin
        repeat (49) @(negedge clk);
        check("ovr before", {63'd0, overrun}, 64'd0);
        msg_in    = 48'hFFFF_FFFF_FFFF;
        msg_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        check("ovr set", {63'd0, overrun}, 64'd1);
      end
    join
    @(negedge clk);
    check_done("ovr");
    check("ovr sticky", {63'd0, overrun}, 64'd1);
    repeat (3) @(negedge clk);

    // Back-to-back with msg_valid held high
    msg_in    = B2B;
    msg_valid = 1'b1;
    @(negedge clk);
    cap      = cyc;
    done_cnt = 0;
    check("b2b cap busy", {63'd0, busy}, 64'd1);
    recv_msg("b2b1", B2B);
    @(negedge clk);
    check_done("b2b1");
    check("b2b restart tx", {63'd0, tx}, 64'd0);
    check("b2b restart busy", {63'd0, busy}, 64'd1);
    msg_valid = 1'b0;
    cap      = cyc;
    done_cnt = 0;
    recv_msg("b2b2", B2B);
    @(negedge clk);
    check_done("b2b2");
    repeat (3) @(negedge clk);

    // Reset during bit 3 of byte 2
    send_msg("mid", ACCEPT);
    recv_byte("mid b0", 8'h41);
    recv_byte("mid b1", 8'h43);
    repeat (18) @(negedge clk);
    check("mid pre tx", {63'd0, tx}, 64'd0);
    check("mid pre busy", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid async tx", {63'd0, tx}, 64'd1);
    check("mid async busy", {63'd0, busy}, 64'd0);
    check("mid async done", {63'd0, done}, 64'd0);
    check("mid async overrun", {63'd0, overrun}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid idle tx", {63'd0, tx}, 64'd1);
    check("mid idle busy", {63'd0, busy}, 64'd0);
    send_msg("after", ACCEPT);
    recv_msg("after", ACCEPT);
    @(negedge clk);
    check_done("after");
    check("after overrun", {63'd0, overrun}, 64'd0);
    repeat (3) @(negedge clk);

    // All-zero status word
    send_msg("zero", 48'h0);
    recv_msg("zero", 48'h0);
    @(negedge clk);
    check_done("zero");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
